mul_seq_ctrl: RTL and testbench

//   Sequencer for the board-level 8x8 multiplier. Replaces the single-cycle

---
 rtl/mul_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mul_seq_ctrl
//   Sequencer for the board-level W x W multiplier. Operands are captured from
//   the switches under button control and multiplied with an iterative
//   shift-and-add datapath, one partial product per clock. The most recent
//   completed result is held in a product register for the display path.
//
// Parameters
//   W      operand width in bits; the product is 2*W bits
//   CNT_W  iteration counter width; 2**CNT_W must be greater than W
//
// Ports
//   clk      in   1     system clock, rising edge
//   rst      in   1     asynchronous reset, active-high
//   sw       in   W     operand value from the switches
//   btn      in   3     raw buttons: [0] load op1, [1] load op2, [2] start
//   product  out  2*W   result of the last completed multiply
//   busy     out  1     high while a multiply is iterating
//   done     out  1     high from completion until the next start or reset
// ----------------------------------------------------------------------------
module mul_seq_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   sw,
    input  logic [2:0]     btn,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter value on the last of the W iterations.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    // One shift-and-add step. The accumulator is 2*W bits, and the largest
    // possible product (2^W-1)^2 fits, so the sum never wraps.
    function automatic logic [2*W-1:0] acc_step(
        input logic [2*W-1:0] acc_in,
        input logic [2*W-1:0] mcand_in,
        input logic           mbit
    );
        return mbit ? (acc_in + mcand_in) : acc_in;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer for the asynchronous buttons.
    // Stage p2: delayed copy used for rising-edge detection.
    // ------------------------------------------------------------------
    logic [2:0] btn_p0;
    logic [2:0] btn_p1;
    logic [2:0] btn_p2;
    logic [2:0] pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_p0 <= 3'b000;
            btn_p1 <= 3'b000;
            btn_p2 <= 3'b000;
        end else begin
            btn_p0 <= btn;
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
        end
    end

    // Exactly one cycle per press regardless of hold time. Because p2 also
    // clears on reset, a button held across reset release still yields one
    // pulse once the synchronizer fills.
    assign pulse = btn_p1 & ~btn_p2;

    logic ld1;
    logic ld2;
    logic start;

    assign ld1   = pulse[0];
    assign ld2   = pulse[1];
    assign start = pulse[2];

    // ------------------------------------------------------------------
    // Control FSM and shift-and-add datapath.
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [W-1:0]     op1;
    logic [W-1:0]     op2;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_nxt;
    logic [CNT_W-1:0] cnt;

    assign acc_nxt = acc_step(acc, mcand, mplier[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op1     <= '0;
            op2     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                RUN: begin
                    // Loads and starts are dropped here; nothing is queued.
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        // Capture the sum including this final step.
                        product <= acc_nxt;
                        state   <= DONE;
                    end
                end

                default: begin
                    // IDLE and DONE behave alike: both accept loads and start.
                    // The start branch reads op1/op2 before this edge's load
                    // lands, so a simultaneous load only affects the next run.
                    if (ld1) begin
                        op1 <= sw;
                    end
                    if (ld2) begin
                        op2 <= sw;
                    end
                    if (start) begin
                        mcand  <= {{W{1'b0}}, op1};
                        mplier <= op2;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
            endcase
        end
    end

    // done is decoded from DONE, so leaving DONE on start clears it in the
    // same edge that raises busy.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_seq_ctrl
//   Randomized and directed stimulus for mul_seq_ctrl. A behavioural model
//   tracks operands, button timing and run length; expected products go into
//   a scoreboard queue that a separate monitor drains whenever done rises.
// ----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic           clk;
    logic           rst;
    logic [W-1:0]   sw;
    logic [2:0]     btn;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    mul_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .btn     (btn),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected products, oldest first.
    logic [2*W-1:0] sb[$];

    // Reference model state.
    logic [W-1:0]   m_op1;
    logic [W-1:0]   m_op2;
    logic [2*W-1:0] m_prod;
    logic [2*W-1:0] m_pending;
    logic           m_done;
    int             busy_left;
    int             pend[3];
    logic [2:0]     prev_b;
    logic [W-1:0]   sw_cur;
    logic           done_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge and apply whatever button actions the model
    // says land on it: a press becomes effective on the 3rd edge after the
    // button rises, and is ignored while a multiply is in progress.
    task automatic edge_step();
        logic [2:0] p;
        logic       running;
        p = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (pend[i] > 0) begin
                pend[i]--;
                if (pend[i] == 0) p[i] = 1'b1;
            end
        end
        @(posedge clk);
        running = (busy_left > 0);
        if (running) begin
            busy_left--;
            if (busy_left == 0) begin
                m_done = 1'b1;
                m_prod = m_pending;
            end
        end else begin
            if (p[2]) begin
                m_pending = {{W{1'b0}}, m_op1} * {{W{1'b0}}, m_op2};
                sb.push_back(m_pending);
                busy_left = W;
                m_done    = 1'b0;
            end
            if (p[0]) m_op1 = sw_cur;
            if (p[1]) m_op2 = sw_cur;
        end
        #1;
        check("busy", 32'(busy), 32'(busy_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("product_hold", 32'(product), 32'(m_prod));
    endtask

    task automatic drive_cycle(input logic [2:0] b, input logic [W-1:0] s);
        @(negedge clk);
        btn    = b;
        sw     = s;
        sw_cur = s;
        for (int i = 0; i < 3; i++) begin
            if (b[i] && !prev_b[i]) pend[i] = 3;
        end
        prev_b = b;
        edge_step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(3'b000, sw_cur);
    endtask

    task automatic press(input logic [2:0] b, input int hold, input logic [W-1:0] s);
        repeat (hold) drive_cycle(b, s);
        idle(4);
    endtask

    // Reset with optional buttons held through release.
    task automatic do_reset(input logic [2:0] bhold, input logic [W-1:0] s);
        @(negedge clk);
        btn    = bhold;
        sw     = s;
        sw_cur = s;
        rst    = 1'b1;
        #1;
        m_op1     = '0;
        m_op2     = '0;
        m_prod    = '0;
        m_done    = 1'b0;
        busy_left = 0;
        sb.delete();
        for (int i = 0; i < 3; i++) pend[i] = 0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_op1", 32'(dut.op1), 32'd0);
        check("rst_op2", 32'(dut.op2), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        prev_b = bhold;
        for (int i = 0; i < 3; i++) pend[i] = bhold[i] ? 3 : 0;
        edge_step();
    endtask

    // Monitor: every rising edge of done must match the oldest expected product.
    initial begin
        done_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got product 0x%0h, expected no completion", product);
                end else begin
                    check("sb_product", 32'(product), 32'(sb.pop_front()));
                end
            end
            done_q = done;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        btn    = 3'b000;
        sw     = '0;
        sw_cur = '0;
        prev_b = 3'b000;
        m_pending = '0;
        do_reset(3'b000, 8'h00);

        // Basic multiply; busy tracked against the model every cycle.
        press(3'b001, 1, 8'h0D);
        press(3'b010, 1, 8'h0B);
        press(3'b100, 1, 8'h00);
        idle(W + 2);
        check("t1_product", 32'(product), 32'h008F);

        // Start and ld1 during a run are both ignored.
        press(3'b100, 1, 8'h00);
        press(3'b101, 1, 8'h02);
        idle(W + 2);
        check("t3_product", 32'(product), 32'h008F);
        check("t3_op1", 32'(dut.op1), 32'h0D);

        // Maximum operands, then a zero operand.
        press(3'b001, 1, 8'hFF);
        press(3'b010, 1, 8'hFF);
        press(3'b100, 1, 8'h00);
        idle(W + 2);
        check("t2_max", 32'(product), 32'hFE01);
        press(3'b001, 1, 8'h00);
        press(3'b100, 1, 8'h00);
        idle(W + 2);
        check("t2_zero", 32'(product), 32'h0000);

        // Long hold with the switches changing: exactly one load.
        for (int i = 0; i < 50; i++) drive_cycle(3'b001, 8'($urandom));
        idle(4);
        check("t4_op1", 32'(dut.op1), 32'(m_op1));
        press(3'b010, 1, 8'h03);
        press(3'b100, 1, 8'h00);
        idle(W + 2);

        // Start and ld1 together: start uses the old op1.
        press(3'b001, 1, 8'h05);
        press(3'b010, 1, 8'h02);
        press(3'b101, 1, 8'h03);
        idle(W + 2);
        check("t5_first", 32'(product), 32'h000A);
        press(3'b100, 1, 8'h00);
        idle(W + 2);
        check("t5_second", 32'(product), 32'h0006);

        // Reset four cycles into a run.
        press(3'b001, 1, 8'h37);
        press(3'b010, 1, 8'h59);
        drive_cycle(3'b100, 8'h00);
        idle(2);
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        idle(3);
        do_reset(3'b000, 8'h00);
        press(3'b100, 1, 8'h00);
        idle(W + 2);
        check("t6_after", 32'(product), 32'h0000);

        // Button held across reset release gives one load.
        do_reset(3'b001, 8'h77);
        repeat (3) drive_cycle(3'b001, 8'h77);
        idle(4);
        check("t8_op1", 32'(dut.op1), 32'h77);
        press(3'b010, 1, 8'h03);
        press(3'b100, 1, 8'h00);
        idle(W + 2);
        check("t8_product", 32'(product), 32'h0165);

        // Random presses, including combinations and presses during runs.
        for (int i = 0; i < 80; i++) begin
            press(3'($urandom_range(1, 7)), $urandom_range(1, 3), 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle(W);
        end
        idle(W + 4);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
